// File: rtl/sipo_deserializer.sv
// sipo_deserializer: strobed serial-in, parallel-out receiver with a registered valid/ready output stage and sticky overrun flag
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             serial_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CW-1:0]    bit_count
);
  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx, shifted, pout_nx;
  logic [CW-1:0]    cnt_nx;
  logic             ov_nx, ovr_nx, last, free;

  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], serial_in} : {serial_in, sreg[WIDTH-1:1]};
  assign last    = bit_count == CW'(WIDTH - 1);
  assign free    = !out_valid || out_ready;

  // next state: clear wins, otherwise each strobed bit shifts; the final bit loads the output stage or flags a drop
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = bit_count;
    pout_nx  = parallel_out;
    ov_nx    = out_valid && !out_ready;
    ovr_nx   = overrun;
    if (clear) begin
      state_nx = IDLE;
      sreg_nx  = '0;
      cnt_nx   = '0;
      ov_nx    = 1'b0;
      ovr_nx   = 1'b0;
    end else if (in_valid) begin
      sreg_nx = shifted;
      if (state == RECV && last) begin
        state_nx = IDLE;
        cnt_nx   = '0;
        pout_nx  = free ? shifted : parallel_out;
        ov_nx    = free ? 1'b1 : ov_nx;
        ovr_nx   = free ? overrun : 1'b1;
      end else begin
        state_nx = RECV;
        cnt_nx   = bit_count + 1'b1;
      end
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sreg         <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nx;
      sreg         <= sreg_nx;
      bit_count    <= cnt_nx;
      parallel_out <= pout_nx;
      out_valid    <= ov_nx;
      overrun      <= ovr_nx;
    end
  end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: scoreboard bench driving an MSB-first and an LSB-first receiver from one serial stream
module tb_sipo_deserializer;
  logic       clk = 1'b0;
  logic       rst_n, clear, serial_in, in_valid, out_ready;
  logic [7:0] pm, pl;
  logic       vm, vl, om, ol;
  logic [2:0] cm, cl;

  int n_pass = 0;
  int n_total = 0;

  logic       bitq[$];
  logic [7:0] qm[$], ql[$];
  logic       m_valid, m_ovr;
  logic [7:0] m_pm, m_pl;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dm (
    .clk(clk), .rst_n(rst_n), .clear(clear), .serial_in(serial_in), .in_valid(in_valid),
    .parallel_out(pm), .out_valid(vm), .out_ready(out_ready), .overrun(om), .bit_count(cm)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dl (
    .clk(clk), .rst_n(rst_n), .clear(clear), .serial_in(serial_in), .in_valid(in_valid),
    .parallel_out(pl), .out_valid(vl), .out_ready(out_ready), .overrun(ol), .bit_count(cl)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  task automatic model_reset();
    bitq.delete();
    qm.delete();
    ql.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_pm    = '0;
    m_pl    = '0;
  endtask

  task automatic reset_chk();
    check("rst_pout_m", pm, 0);
    check("rst_valid_m", vm, 0);
    check("rst_ovr_m", om, 0);
    check("rst_cnt_m", cm, 0);
    check("rst_pout_l", pl, 0);
    check("rst_valid_l", vl, 0);
    check("rst_ovr_l", ol, 0);
    check("rst_cnt_l", cl, 0);
  endtask

  // drive one cycle of inputs and predict the result of the next rising edge
  task automatic step(input logic iv, input logic b, input logic rdy, input logic clr);
    logic [7:0] wm, wl;
    @(negedge clk);
    in_valid  = iv;
    serial_in = iv ? b : 1'bx;
    out_ready = rdy;
    clear     = clr;
    if (clr) begin
      bitq.delete();
      qm.delete();
      ql.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (iv) begin
        bitq.push_back(b);
        if (bitq.size() == 8) begin
          wm = '0;
          wl = '0;
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = bitq[i];
            wl[i]   = bitq[i];
          end
          if (!m_valid) begin
            m_valid = 1'b1;
            m_pm    = wm;
            m_pl    = wl;
            qm.push_back(wm);
            ql.push_back(wl);
          end else m_ovr = 1'b1;
          bitq.delete();
        end
      end
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy, input logic last_rdy, input int maxgap);
    for (int i = 7; i >= 0; i--) begin
      repeat ($urandom_range(maxgap)) step(1'b0, 1'b0, rdy, 1'b0);
      step(1'b1, w[i], (i == 0) ? last_rdy : rdy, 1'b0);
    end
  endtask

  // monitor: compare every cycle, and pop the scoreboard whenever a fresh word is presented
  initial begin
    logic pvm, pvl;
    pvm = 1'b0;
    pvl = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pvm = 1'b0;
        pvl = 1'b0;
      end else begin
        check("valid_m", vm, m_valid);
        check("valid_l", vl, m_valid);
        check("ovr_m", om, m_ovr);
        check("ovr_l", ol, m_ovr);
        check("cnt_m", cm, bitq.size());
        check("cnt_l", cl, bitq.size());
        check("pout_m", pm, m_pm);
        check("pout_l", pl, m_pl);
        if (vm && (!pvm || out_ready)) begin
          if (qm.size() == 0) begin
            n_total++;
            $display("FAIL word_m at %0t: got unexpected word %0h expected none", $time, pm);
          end else check("word_m", pm, qm.pop_front());
        end
        if (vl && (!pvl || out_ready)) begin
          if (ql.size() == 0) begin
            n_total++;
            $display("FAIL word_l at %0t: got unexpected word %0h expected none", $time, pl);
          end else check("word_l", pl, ql.pop_front());
        end
        pvm = vm;
        pvl = vl;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; serial_in = 1'b0; out_ready = 1'b0; clear = 1'b0;
    model_reset();
    #2 reset_chk();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'hA5, 1'b1, 1'b1, 0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'hA5, 1'b1, 1'b1, 3);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 2);
    send_word(8'hC3, 1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0, 1);
    send_word(8'h81, 1'b0, 1'b1, 1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 reset_chk();
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'h5A, 1'b1, 1'b1, 1);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    send_word(8'h11, 1'b0, 1'b0, 0);
    send_word(8'h22, 1'b0, 1'b0, 0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send_word(8'h96, 1'b1, 1'b1, 2);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 2) step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1);
      else step(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1'b0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_m", qm.size(), 0);
    check("drain_l", ql.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out receiver. It is the receive-side counterpart of the team's PISO serializer. It assembles WIDTH serial bits, qualified by a per-bit strobe, into a parallel word. Each completed word is presented through a registered valid/ready output stage, and words lost to backpressure are flagged. It sits between a serial link front-end and word-oriented logic.

Parameters:
WIDTH, 8, word length in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, bit order. 1: the first received bit lands in parallel_out[WIDTH-1]. 0: the first received bit lands in parallel_out[0].
CW, $clog2(WIDTH), width of the bit counter (derived; do not override).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous reset, active-low.
clear  input  1  synchronous abort; discards the partial word and clears flags.
serial_in  input  1  serial data bit.
in_valid  input  1  serial_in is sampled on the rising edge where in_valid=1.
parallel_out  output  WIDTH  assembled word; stable while out_valid=1.
out_valid  output  1  parallel_out holds an unconsumed word.
out_ready  input  1  consumer accepts the word on the edge where out_valid & out_ready.
overrun  output  1  sticky; a completed word was dropped.
bit_count  output  CW  number of bits received so far in the current word.

Behaviour:
- Reset (rst_n=0, async): the following are all 0 immediately and remain 0 until rst_n deasserts.
  - Outputs parallel_out, out_valid, overrun, bit_count.
  - Internal shift register.
  - FSM, which is forced to IDLE.
- FSM states:
  - IDLE: bit_count=0. in_valid goes to RECV after shifting the first bit.
  - RECV: each in_valid shifts one bit and increments bit_count. An in_valid with bit_count==WIDTH-1 completes the word; bit_count returns to 0 and the FSM goes to IDLE.
- Shift direction:
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
- Cycles with in_valid=0 hold all state. Gaps between bits of any length are legal.
- Word completion, at the edge sampling the last bit:
  - The complete word, including the bit just sampled, is transferred to parallel_out if the output stage is free.
  - The output stage is free when out_valid=0, or when out_valid=1 and out_ready=1 on that same edge.
  - out_valid is high from the following cycle. Latency is 1 clock from the last-bit edge to out_valid visible.
  - If the output stage is not free, the new word is discarded. parallel_out and out_valid are unchanged and overrun is set to 1.
- Output handshake:
  - An edge with out_valid & out_ready consumes the word; out_valid drops next cycle unless a new word loads on the same edge.
  - parallel_out is not modified while out_valid=1 except by a same-edge consume-and-reload.
  - After a consume, parallel_out keeps its last value and only out_valid deasserts.
- overrun: once set, stays 1 until clear or reset. Further drops keep it 1. It does not block reception.
- clear (synchronous): has priority over in_valid and out_ready on the same edge. It zeroes the shift register and bit_count, forces IDLE, sets out_valid=0 and overrun=0, and leaves parallel_out value unchanged.
- Reset mid-word: the partial word is lost. The first in_valid after rst_n deasserts is bit 0 of a new word.
- X/undefined serial_in when in_valid=0 must not affect any state.

Test Plan:
1. MSB_FIRST=1, WIDTH=8. Drive 0xA5 as bits 1,0,1,0,0,1,0,1 on 8 consecutive in_valid edges with out_ready=1. Expect out_valid=1 one cycle after the 8th edge, parallel_out=0xA5, bit_count back to 0, and out_valid dropping the following cycle.
2. MSB_FIRST=0, WIDTH=8. Drive 0xA5 LSB first (1,0,1,0,0,1,0,1) with 0-3 idle cycles between bits. Expect parallel_out=0xA5, and bit_count incrementing only on in_valid edges.
3. Backpressure: hold out_ready=0 and send 0x3C then 0xC3. Expect parallel_out=0x3C, out_valid=1, and overrun=1 one cycle after the last bit of 0xC3. Raise out_ready for one cycle: expect out_valid=0 and overrun still 1.
4. Same-edge consume and reload: 0x3C is pending, and the last bit of 0x81 coincides with out_ready=1. Expect parallel_out=0x81 and out_valid staying 1 continuously, with overrun=0.
5. Abort: after 3 bits of a word, assert rst_n=0 asynchronously mid-cycle. Expect all outputs at 0 immediately. Then send 0x5A in full and expect parallel_out=0x5A. Repeat using clear=1 after 5 bits plus a pending overrun: expect bit_count=0, overrun=0, out_valid=0, and a clean next word.
